tx_word_serializer: RTL and testbench

TX_WORD_SERIALIZER -- requirements
Module: tx_word_serializer

---
 rtl/tx_word_serializer.sv | 147 ++++++++++++++
 tb/tb_tx_word_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tx_word_serializer.sv
// Frame serializer: walks a 16:1 word mux via sel and sends each selected word
// as a UART-style character (start 0, Q data bits LSB first, stop 1).
module tx_word_serializer #(
    parameter int Q        = 32,
    parameter int BAUD_DIV = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   num_words,
    input  logic [Q-1:0] word_in,
    output logic [3:0]   sel,
    output logic         tx_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = 16;
    localparam int BW = $clog2(Q + 2);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(Q + 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     sel_q, sel_d;
    logic [3:0]     last_q, last_d;
    logic [Q-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 4'd0;
            last_q  <= 4'd0;
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; line outputs are derived from the current state and
    // registered, so they trail the state by one cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                sel_d = 4'd0;
                if (start && (num_words != 5'd0)) begin
                    last_d  = (num_words > 5'd16) ? 4'd15 : 4'(num_words - 5'd1);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                busy_d  = 1'b1;
                shreg_d = word_in;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (bit_q == '0) begin
                    tx_d = 1'b0;
                end else if (bit_q == BIT_LAST) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d = shreg_q[0];
                end

                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if ((bit_q != '0) && (bit_q != BIT_LAST)) begin
                        shreg_d = shreg_q >> 1;
                    end else begin
                        shreg_d = shreg_q;
                    end
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (sel_q == last_q) begin
                            sel_d   = 4'd0;
                            state_d = S_DONE;
                        end else begin
                            sel_d   = sel_q + 4'd1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                sel_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                sel_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel    = sel_q;
    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Directed bench for tx_word_serializer: a serial-line monitor decodes each
// character and checks it against a scoreboard of expected words.
module tb_tx_word_serializer;

    localparam int Q  = 32;
    localparam int BD = 4;
    localparam int WP = 1 + (Q + 2) * BD;   // cycles per word: LOAD + 34 bits

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   num_words = 5'd0;
    logic [Q-1:0] word_in;
    logic [3:0]   sel;
    logic         tx_out, busy, done;

    logic [Q-1:0] mux_tbl [16];
    logic         tog_en = 1'b0;
    logic [Q-1:0] tog_w = '0;
    int unsigned  cyc = 0;

    int           checks = 0;
    int           errors = 0;
    logic [Q-1:0] exp_q [$];
    int           frames_rx = 0;
    int           epoch = 0;
    logic         mon_en = 1'b0;

    tx_word_serializer #(.Q(Q), .BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .word_in   (word_in),
        .sel       (sel),
        .tx_out    (tx_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 16:1 word mux, or a word that flips every cycle for the capture test.
    assign word_in = tog_en ? (cyc[0] ? ~tog_w : tog_w) : mux_tbl[sel];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Line monitor: samples mid-bit; frames cut short by reset are discarded.
    always begin : mon
        logic [Q-1:0] w;
        int           ep;
        @(posedge clk); #1;
        if (mon_en && tx_out === 1'b0) begin
            ep = epoch;
            w  = '0;
            repeat (2) begin @(posedge clk); #1; end
            if (ep == epoch) chk("start_bit", 32'(tx_out), 32'd0);
            for (int i = 0; i < Q; i++) begin
                repeat (BD) begin @(posedge clk); #1; end
                w[i] = tx_out;
            end
            repeat (BD) begin @(posedge clk); #1; end
            if (ep == epoch) begin
                chk("stop_bit", 32'(tx_out), 32'd1);
                frames_rx++;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("word", w, exp_q.pop_front());
            end
        end
    end

    task automatic run_frame(input string tag, input int nw, input int n_exp,
                             input bit tog, input bit extra);
        int busy_n = 0;
        int done_n = 0;
        int done_k = -1;
        int low_n  = 0;
        int f0;
        int limit;
        limit = (n_exp == 0) ? 60 : n_exp * WP + 10;
        f0    = frames_rx;
        if (!tog) for (int j = 0; j < n_exp; j++) exp_q.push_back(mux_tbl[j]);
        tog_en = tog;
        @(posedge clk); #1;
        start = 1'b1;
        num_words = 5'(nw);
        @(posedge clk); #1;
        start = 1'b0;
        if (tog && n_exp > 0) exp_q.push_back(cyc[0] ? ~tog_w : tog_w);
        for (int k = 0; k <= limit; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (extra && (k == 0 || k == 60)) begin
                start = 1'b1;
                num_words = 5'd16;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin done_n++; done_k = k; end
            if (!tx_out) low_n++;
            if (k < n_exp * WP && (k % WP) == 0) chk("sel_step", 32'(sel), 32'(k / WP));
            if (n_exp > 0 && k == 1) chk("load_tx_high", 32'(tx_out), 32'd1);
            if (n_exp > 0 && k == 2) chk("first_start_bit", 32'(tx_out), 32'd0);
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(n_exp * WP));
        chk({tag, "_done_count"}, 32'(done_n), (n_exp > 0) ? 32'd1 : 32'd0);
        if (n_exp > 0) chk({tag, "_done_time"}, 32'(done_k), 32'(n_exp * WP + 1));
        else           chk({tag, "_tx_low"}, 32'(low_n), 32'd0);
        repeat (20) begin @(posedge clk); #1; end
        chk({tag, "_frames"}, 32'(frames_rx - f0), 32'(n_exp));
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx_out), 32'd1);
        chk({tag, "_idle_sel"}, 32'(sel), 32'd0);
        tog_en = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < 16; j++) mux_tbl[j] = 32'(j);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        mux_tbl[0] = 32'hA5A5_0F0F;
        run_frame("single", 1, 1, 1'b0, 1'b0);
        mux_tbl[0] = 32'd0;

        run_frame("full16", 16, 16, 1'b0, 1'b0);
        run_frame("zero", 0, 0, 1'b0, 1'b0);
        run_frame("sat31", 31, 16, 1'b0, 1'b0);
        run_frame("ignore_start", 2, 2, 1'b0, 1'b1);

        tog_w = 32'h3C5A_96E1;
        run_frame("toggle", 1, 1, 1'b1, 1'b0);

        // Reset in the middle of a data bit of word 3 of a 4-word frame.
        for (int j = 0; j < 4; j++) exp_q.push_back(mux_tbl[j]);
        @(posedge clk); #1;
        start = 1'b1;
        num_words = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (WP * 3 + 60) @(posedge clk);
        #3;
        chk("pre_reset_sel", 32'(sel), 32'd3);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        epoch++;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_reset_tx", 32'(tx_out), 32'd1);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_sel", 32'(sel), 32'd0);
        chk("mid_reset_done", 32'(done), 32'd0);
        #10;
        rst_n = 1'b1;
        repeat (150) begin @(posedge clk); #1; end
        run_frame("post_reset", 2, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
